mips_ctrl_fsm: RTL

Parametrised multi-cycle control path for the MIPS datapath. It replaces the separate strobe FSM and combinational decoder with one registered controller. It decodes R-type, lw, sw, beq, addi and j, and holds the write and read strobes for configurable cycle counts to suit slower memories. It also reports busy, done and illegal-opcode status back to the instruction sequencer.

---
 rtl/mips_ctrl_fsm.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mips_ctrl_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mips_ctrl_fsm: registered multi-cycle MIPS control path with strobe dwell |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module mips_ctrl_fsm #(
  parameter int STROBE_CYCLES = 1,
  parameter int MEM_LATENCY   = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       newinstr,
  input  logic [5:0] opcode,
  output logic       regwrite,
  output logic       memread,
  output logic       memwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrc,
  output logic [1:0] aluop,
  output logic       branch,
  output logic       jump,
  output logic       busy,
  output logic       done,
  output logic       illegal
);

  localparam logic [5:0] C_OP_RTYPE = 6'd0;
  localparam logic [5:0] C_OP_J     = 6'd2;
  localparam logic [5:0] C_OP_BEQ   = 6'd4;
  localparam logic [5:0] C_OP_ADDI  = 6'd8;
  localparam logic [5:0] C_OP_LW    = 6'd35;
  localparam logic [5:0] C_OP_SW    = 6'd43;

  localparam logic [3:0] C_STROBE_LOAD = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] C_MEM_LOAD    = 4'(MEM_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEMRD  = 3'd3,
    MEMWR  = 3'd4,
    WB     = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_count;
  logic [3:0] w_count_next;
  logic [5:0] r_opcode;

  function automatic logic is_legal(input logic [5:0] op);
    case (op)
      C_OP_RTYPE, C_OP_J, C_OP_BEQ, C_OP_ADDI, C_OP_LW, C_OP_SW: is_legal = 1'b1;
      default: is_legal = 1'b0;
    endcase
  endfunction

  // {memtoreg, regdst, alusrc, aluop}
  function automatic logic [4:0] decode_sel(input logic [5:0] op);
    case (op)
      C_OP_RTYPE: decode_sel = 5'b01010;
      C_OP_LW:    decode_sel = 5'b10100;
      C_OP_SW:    decode_sel = 5'b00100;
      C_OP_BEQ:   decode_sel = 5'b00001;
      C_OP_ADDI:  decode_sel = 5'b00100;
      default:    decode_sel = 5'b00000;
    endcase
  endfunction

  always_comb begin
    w_next       = r_state;
    w_count_next = r_count;
    if (newinstr) begin
      w_next = DECODE;
    end else begin
      case (r_state)
        IDLE:   w_next = IDLE;
        DECODE: w_next = is_legal(r_opcode) ? EXEC : DONE;
        EXEC: begin
          case (r_opcode)
            C_OP_RTYPE, C_OP_ADDI: begin
              w_next       = WB;
              w_count_next = C_STROBE_LOAD;
            end
            C_OP_LW: begin
              w_next       = MEMRD;
              w_count_next = C_MEM_LOAD;
            end
            C_OP_SW: begin
              w_next       = MEMWR;
              w_count_next = C_STROBE_LOAD;
            end
            default: w_next = DONE;
          endcase
        end
        MEMRD: begin
          if (r_count == 4'd0) begin
            w_next       = WB;
            w_count_next = C_STROBE_LOAD;
          end else begin
            w_count_next = r_count - 4'd1;
          end
        end
        MEMWR, WB: begin
          if (r_count == 4'd0) w_next = DONE;
          else w_count_next = r_count - 4'd1;
        end
        DONE:    w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so each one lines up with the state it describes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_count  <= 4'd0;
      r_opcode <= 6'd0;
      regwrite <= 1'b0;
      memread  <= 1'b0;
      memwrite <= 1'b0;
      memtoreg <= 1'b0;
      regdst   <= 1'b0;
      alusrc   <= 1'b0;
      aluop    <= 2'b00;
      branch   <= 1'b0;
      jump     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_count  <= w_count_next;
      if (newinstr) r_opcode <= opcode;
      regwrite <= (w_next == WB);
      memread  <= (w_next == MEMRD);
      memwrite <= (w_next == MEMWR);
      branch   <= (w_next == EXEC) && (r_opcode == C_OP_BEQ);
      jump     <= (w_next == EXEC) && (r_opcode == C_OP_J);
      busy     <= (w_next != IDLE) && (w_next != DONE);
      done     <= (w_next == DONE);
      illegal  <= (w_next == DONE) && (r_state == DECODE);
      // Entering DECODE only happens on newinstr, so the incoming opcode equals the copy being latched.
      if (newinstr) begin
        {memtoreg, regdst, alusrc, aluop} <= decode_sel(opcode);
      end else if (w_next == IDLE) begin
        {memtoreg, regdst, alusrc, aluop} <= 5'b00000;
      end
    end
  end

endmodule
`default_nettype wire
